// File: rtl/ca_prng_engine.sv
// ---------------------------------------------------------------------------
// ca_prng_engine
//
// Purpose:
//   One-dimensional hybrid cellular-automaton random-number engine. An
//   N_CELLS-wide grid of cells is updated in parallel once per step. Each
//   cell applies RULE_A or RULE_B (chosen per cell by i_rule_sel) to its
//   neighbourhood of radius NEIGHBORHOOD/2. The boundary is either null
//   (out-of-range cells read as 0) or periodic (indices wrap). After a seed
//   load the grid runs WARMUP_STEPS discarded generations. It then packs
//   the pre-update centre-cell bit stream into OUT_W-bit words, which are
//   delivered over a valid/ready interface.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_enable     step enable (0 freezes grid, counters and FSM)
//   i_seed_load  load i_seed (or the default seed when i_seed == 0)
//   i_seed       seed value, N_CELLS bits
//   i_rule_sel   per-cell rule select, 0 = RULE_A, 1 = RULE_B
//   i_periodic   boundary mode, 1 = wrap, 0 = null
//   o_data       output word, OUT_W bits
//   o_valid      o_data valid
//   i_ready      consumer accepts o_data when o_valid && i_ready
//   o_state      current grid contents
//   o_busy       high while discarding warm-up generations
//   o_lockup     one-cycle pulse when an all-zero grid was replaced
// ---------------------------------------------------------------------------
module ca_prng_engine #(
    parameter int          N_CELLS      = 32,
    parameter int          NEIGHBORHOOD = 2,
    parameter int unsigned RULE_A       = 30,
    parameter int unsigned RULE_B       = 150,
    parameter int          OUT_W        = 8,
    parameter int          WARMUP_STEPS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_seed_load,
    input  logic [N_CELLS-1:0] i_seed,
    input  logic [N_CELLS-1:0] i_rule_sel,
    input  logic               i_periodic,
    output logic [OUT_W-1:0]   o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [N_CELLS-1:0] o_state,
    output logic               o_busy,
    output logic               o_lockup
);

    localparam int R         = NEIGHBORHOOD / 2;
    localparam int NB_W      = NEIGHBORHOOD + 1;
    localparam int RULE_BITS = 2 ** NB_W;
    localparam int CENTRE    = N_CELLS / 2;
    localparam int CNT_W     = $clog2(OUT_W);
    localparam int WARM_W    = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;

    localparam logic [RULE_BITS-1:0] RULE_A_TBL   = RULE_BITS'(RULE_A);
    localparam logic [RULE_BITS-1:0] RULE_B_TBL   = RULE_BITS'(RULE_B);
    localparam logic [N_CELLS-1:0]   DEFAULT_SEED = N_CELLS'(1) << CENTRE;
    localparam logic [CNT_W-1:0]     LAST_BIT     = CNT_W'(OUT_W - 1);
    localparam logic [WARM_W-1:0]    WARM_LAST    = WARM_W'(WARMUP_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Where a seed load or leaving IDLE lands: warm-up is skipped entirely
    // when no discarded generations are configured.
    localparam state_t POST_SEED = (WARMUP_STEPS == 0) ? ST_RUN : ST_WARMUP;

    state_t             state_q, state_d;
    logic [N_CELLS-1:0] grid_q, grid_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [OUT_W-2:0]   coll_q, coll_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               lockup_q, lockup_d;

    logic [N_CELLS-1:0] step_grid;
    logic [OUT_W-2:0]   coll_shift;
    logic               centre_bit;
    logic               stall;
    logic               do_step;

    // -----------------------------------------------------------------------
    // Next-generation logic. Neighbourhood bit gj holds cell gi+gj-R, so the
    // highest neighbour index lands in the MSB of the rule index.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
        logic [NB_W-1:0] nbhd;

        for (genvar gj = 0; gj < NB_W; gj++) begin : g_nb
            localparam int POS = gi + gj - R;
            if (POS < 0) begin : g_low
                assign nbhd[gj] = i_periodic & grid_q[POS + N_CELLS];
            end else if (POS >= N_CELLS) begin : g_high
                assign nbhd[gj] = i_periodic & grid_q[POS - N_CELLS];
            end else begin : g_in
                assign nbhd[gj] = grid_q[POS];
            end
        end

        assign step_grid[gi] = i_rule_sel[gi] ? RULE_B_TBL[nbhd] : RULE_A_TBL[nbhd];
    end

    assign centre_bit = grid_q[CENTRE];

    // Collector shifts the newest bit into its LSB; with a 2-bit word the
    // collector is a single bit and simply takes the new bit.
    if (OUT_W > 2) begin : g_coll_wide
        assign coll_shift = {coll_q[OUT_W-3:0], centre_bit};
    end else begin : g_coll_narrow
        assign coll_shift = centre_bit;
    end

    // The last bit of a word cannot be taken while the previous word is
    // still waiting: holding the step keeps grid and counter intact.
    assign stall   = (state_q == ST_RUN) && (bit_cnt_q == LAST_BIT) && valid_q && !i_ready;
    assign do_step = i_enable && (state_q != ST_IDLE) && !stall;

    always_comb begin
        state_d    = state_q;
        grid_d     = grid_q;
        warm_cnt_d = warm_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        coll_d     = coll_q;
        data_d     = data_q;
        valid_d    = valid_q;
        lockup_d   = 1'b0;

        if (i_seed_load) begin
            grid_d     = (i_seed == '0) ? DEFAULT_SEED : i_seed;
            state_d    = POST_SEED;
            warm_cnt_d = '0;
            bit_cnt_d  = '0;
            coll_d     = '0;
            valid_d    = 1'b0;
        end else begin
            // The handshake completes even while stepping is disabled; a
            // word loaded below in the same cycle overrides this clear.
            if (valid_q && i_ready) begin
                valid_d = 1'b0;
            end

            if (i_enable && (state_q == ST_IDLE)) begin
                state_d = POST_SEED;
            end

            if (do_step) begin
                if (step_grid == '0) begin
                    grid_d   = DEFAULT_SEED;
                    lockup_d = 1'b1;
                end else begin
                    grid_d = step_grid;
                end

                if (state_q == ST_WARMUP) begin
                    if (warm_cnt_q == WARM_LAST) begin
                        warm_cnt_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end else begin
                    if (bit_cnt_q == LAST_BIT) begin
                        data_d    = {coll_q, centre_bit};
                        valid_d   = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        coll_d    = coll_shift;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            grid_q     <= DEFAULT_SEED;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            coll_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            lockup_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grid_q     <= grid_d;
            warm_cnt_q <= warm_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            coll_q     <= coll_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            lockup_q   <= lockup_d;
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_state  = grid_q;
    assign o_busy   = (state_q == ST_WARMUP);
    assign o_lockup = lockup_q;

endmodule

// File: tb/tb_ca_prng_engine.sv
// ---------------------------------------------------------------------------
// tb_ca_prng_engine
//
// Purpose:
//   Self-checking bench for ca_prng_engine. Four 8-cell instances share one
//   set of input drivers:
//     u_main  RULE_A=30, RULE_B=150, OUT_W=4, no warm-up (model-tracked)
//     u_wrap  RULE_A=90             (boundary behaviour)
//     u_zero  RULE_A=0              (all-zero recovery)
//     u_hyb   RULE_B=204, 3 warm-up steps (identity rule, warm-up timing)
//   u_main is compared against a behavioural model on every cycle; the other
//   instances get directed checks.
// ---------------------------------------------------------------------------
module tb_ca_prng_engine;

    logic       clk = 1'b0;
    logic       rst, enable, seed_load, periodic, ready;
    logic [7:0] seed, sel;

    always #5 clk = ~clk;

    logic [3:0] main_data, wrap_data, zero_data, hyb_data;
    logic       main_valid, wrap_valid, zero_valid, hyb_valid;
    logic [7:0] main_state, wrap_state, zero_state, hyb_state;
    logic       main_busy, wrap_busy, zero_busy, hyb_busy;
    logic       main_lock, wrap_lock, zero_lock, hyb_lock;

    ca_prng_engine #(.N_CELLS(8), .NEIGHBORHOOD(2), .RULE_A(30), .RULE_B(150),
                     .OUT_W(4), .WARMUP_STEPS(0)) u_main (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_seed_load(seed_load),
        .i_seed(seed), .i_rule_sel(sel), .i_periodic(periodic),
        .o_data(main_data), .o_valid(main_valid), .i_ready(ready),
        .o_state(main_state), .o_busy(main_busy), .o_lockup(main_lock));

    ca_prng_engine #(.N_CELLS(8), .NEIGHBORHOOD(2), .RULE_A(90), .RULE_B(150),
                     .OUT_W(4), .WARMUP_STEPS(0)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_seed_load(seed_load),
        .i_seed(seed), .i_rule_sel(sel), .i_periodic(periodic),
        .o_data(wrap_data), .o_valid(wrap_valid), .i_ready(ready),
        .o_state(wrap_state), .o_busy(wrap_busy), .o_lockup(wrap_lock));

    ca_prng_engine #(.N_CELLS(8), .NEIGHBORHOOD(2), .RULE_A(0), .RULE_B(150),
                     .OUT_W(4), .WARMUP_STEPS(0)) u_zero (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_seed_load(seed_load),
        .i_seed(seed), .i_rule_sel(sel), .i_periodic(periodic),
        .o_data(zero_data), .o_valid(zero_valid), .i_ready(ready),
        .o_state(zero_state), .o_busy(zero_busy), .o_lockup(zero_lock));

    ca_prng_engine #(.N_CELLS(8), .NEIGHBORHOOD(2), .RULE_A(30), .RULE_B(204),
                     .OUT_W(4), .WARMUP_STEPS(3)) u_hyb (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_seed_load(seed_load),
        .i_seed(seed), .i_rule_sel(sel), .i_periodic(periodic),
        .o_data(hyb_data), .o_valid(hyb_valid), .i_ready(ready),
        .o_state(hyb_state), .o_busy(hyb_busy), .o_lockup(hyb_lock));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference: CA rules with plain arithmetic -------------
    function automatic logic [7:0] ref_raw(input logic [7:0] g, input int ra, input int rb,
                                           input logic [7:0] s, input logic per);
        logic [7:0] n;
        int idx, p, b;
        for (int k = 0; k < 8; k++) begin
            idx = 0;
            for (int j = -1; j <= 1; j++) begin
                p = k + j;
                if (p < 0 || p > 7) b = per ? int'(g[(p + 8) % 8]) : 0;
                else                b = int'(g[p]);
                idx += b << (j + 1);
            end
            n[k] = (((s[k] ? rb : ra) >> idx) & 1) != 0;
        end
        return n;
    endfunction

    function automatic logic [7:0] ref_next(input logic [7:0] g, input int ra, input int rb,
                                            input logic [7:0] s, input logic per);
        logic [7:0] n;
        n = ref_raw(g, ra, rb, s, per);
        return (n == 8'h00) ? 8'h10 : n;
    endfunction

    function automatic logic [7:0] ref_grid(input logic [7:0] sd, input int steps);
        logic [7:0] g;
        g = sd;
        for (int i = 0; i < steps; i++) g = ref_next(g, 30, 150, 8'h00, 1'b0);
        return g;
    endfunction

    // Word n (0-based) produced by u_main from seed sd, RULE_A, null boundary.
    function automatic logic [3:0] ref_word(input logic [7:0] sd, input int n);
        logic [7:0] g;
        logic [3:0] w;
        g = sd;
        w = 4'h0;
        for (int i = 0; i < 4 * (n + 1); i++) begin
            w = {w[2:0], g[4]};
            g = ref_next(g, 30, 150, 8'h00, 1'b0);
        end
        return w;
    endfunction

    // ---------------- behavioural model of u_main ---------------------------
    logic [7:0] md_grid;
    int         md_mode;     // 0 = idle, 1 = running
    bit         md_bits[$];  // bits of the word being collected
    logic [3:0] md_data;
    logic       md_valid;
    logic       md_lock;

    task automatic model_update();
        logic [7:0] nx;
        md_lock = 1'b0;
        if (rst) begin
            md_grid = 8'h10; md_mode = 0; md_bits.delete(); md_data = 4'h0; md_valid = 1'b0;
        end else if (seed_load) begin
            md_grid = (seed == 8'h00) ? 8'h10 : seed;
            md_mode = 1; md_bits.delete(); md_valid = 1'b0;
        end else if (!enable) begin
            if (md_valid && ready) md_valid = 1'b0;
        end else if (md_mode == 0) begin
            md_mode = 1;
            if (md_valid && ready) md_valid = 1'b0;
        end else if (!(md_bits.size() == 3 && md_valid && !ready)) begin
            md_bits.push_back(md_grid[4]);
            nx = ref_raw(md_grid, 30, 150, sel, periodic);
            if (nx == 8'h00) begin nx = 8'h10; md_lock = 1'b1; end
            md_grid = nx;
            if (md_bits.size() == 4) begin
                md_data  = {md_bits[0], md_bits[1], md_bits[2], md_bits[3]};
                md_valid = 1'b1;
                md_bits.delete();
            end else if (md_valid && ready) begin
                md_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        chk("model_state", main_state, md_grid);
        chk("model_valid", main_valid, md_valid);
        chk("model_lockup", main_lock, md_lock);
        chk("model_busy", main_busy, 1'b0);
        if (md_valid) chk("model_data", main_data, md_data);
    endtask

    task automatic wait_main_valid(input int budget);
        for (int i = 0; i < budget && !main_valid; i++) tick();
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed = s; seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    logic [3:0] w0;
    logic [3:0] hyb_exp;
    logic [7:0] hyb_seeds [2];

    initial begin
        rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = 8'h00;
        sel = 8'h00; periodic = 1'b0; ready = 1'b1;
        md_grid = 8'h10; md_mode = 0; md_data = 4'h0; md_valid = 1'b0; md_lock = 1'b0;

        // Reset state
        tick(); tick();
        chk("reset_state", main_state, 8'h10);
        chk("reset_valid", main_valid, 1'b0);
        chk("reset_data", main_data, 4'h0);
        chk("reset_busy", hyb_busy, 1'b0);
        chk("reset_lockup", zero_lock, 1'b0);
        rst = 1'b0;

        // Bring-up: first enabled cycle leaves IDLE, then one step per cycle
        enable = 1'b1;
        tick();
        chk("bringup_idle_state", main_state, 8'h10);
        tick();
        chk("bringup_step1", main_state, 8'b0011_1000);
        tick(); tick();
        chk("bringup_no_word_yet", main_valid, 1'b0);
        tick();
        chk("bringup_valid", main_valid, 1'b1);
        chk("bringup_word", main_data, 4'b1101);

        // Boundary modes with rule 90
        periodic = 1'b1;
        load_seed(8'h01);
        chk("wrap_seed", wrap_state, 8'h01);
        tick();
        chk("wrap_periodic", wrap_state, 8'b1000_0010);
        periodic = 1'b0;
        load_seed(8'h01);
        tick();
        chk("wrap_null", wrap_state, 8'b0000_0010);

        // Lock-up recovery with rule 0
        load_seed(8'hA5);
        chk("lock_seed_state", zero_state, 8'hA5);
        chk("lock_seed_pulse", zero_lock, 1'b0);
        tick();
        chk("lock_state", zero_state, 8'h10);
        chk("lock_pulse", zero_lock, 1'b1);
        enable = 1'b0;
        tick();
        chk("lock_pulse_end", zero_lock, 1'b0);
        load_seed(8'h00);
        chk("seed_zero_main", main_state, 8'h10);
        chk("seed_zero_wrap", wrap_state, 8'h10);
        enable = 1'b1;

        // Back-pressure
        ready = 1'b0;
        load_seed(8'h5A);
        w0 = ref_word(8'h5A, 0);
        wait_main_valid(8);
        chk("bp_first_valid", main_valid, 1'b1);
        chk("bp_first_word", main_data, w0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("bp_state", main_state, ref_grid(8'h5A, 4 + ((k < 3) ? k : 3)));
            chk("bp_data_hold", main_data, w0);
            chk("bp_valid_hold", main_valid, 1'b1);
        end
        ready = 1'b1;
        tick();
        chk("bp_next_valid", main_valid, 1'b1);
        chk("bp_next_word", main_data, ref_word(8'h5A, 1));
        chk("bp_resume_state", main_state, ref_grid(8'h5A, 8));
        tick();
        chk("bp_drained", main_valid, 1'b0);

        // Warm-up and identity rule: words are the replicated centre bit
        sel = 8'hFF;
        hyb_seeds[0] = 8'hB7;
        hyb_seeds[1] = 8'h2C;
        for (int s = 0; s < 2; s++) begin
            hyb_exp = hyb_seeds[s][4] ? 4'hF : 4'h0;
            load_seed(hyb_seeds[s]);
            chk("hyb_busy_start", hyb_busy, 1'b1);
            for (int k = 1; k <= 7; k++) begin
                tick();
                chk("hyb_busy", hyb_busy, (k < 3) ? 1'b1 : 1'b0);
                chk("hyb_state", hyb_state, hyb_seeds[s]);
                chk("hyb_valid", hyb_valid, (k == 7) ? 1'b1 : 1'b0);
            end
            chk("hyb_word", hyb_data, hyb_exp);
            tick(); tick(); tick(); tick();
            chk("hyb_word2_valid", hyb_valid, 1'b1);
            chk("hyb_word2", hyb_data, hyb_exp);
        end

        // Seed load mid-word drops the pending word
        sel = 8'h00;
        ready = 1'b0;
        load_seed(8'h3C);
        wait_main_valid(8);
        chk("mw_valid", main_valid, 1'b1);
        tick(); tick();
        chk("mw_pending", main_valid, 1'b1);
        load_seed(8'hC3);
        chk("mw_dropped", main_valid, 1'b0);
        ready = 1'b1;
        tick(); tick(); tick();
        chk("mw_not_yet", main_valid, 1'b0);
        tick();
        chk("mw_new_valid", main_valid, 1'b1);
        chk("mw_new_word", main_data, ref_word(8'hC3, 0));

        // Reset while a word is valid
        chk("rst_pre_valid", main_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_state", main_state, 8'h10);
        chk("rst_valid", main_valid, 1'b0);
        chk("rst_data", main_data, 4'h0);
        chk("rst_lockup", main_lock, 1'b0);
        chk("rst_hyb_busy", hyb_busy, 1'b0);
        chk("rst_hyb_state", hyb_state, 8'h10);
        rst = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            seed_load = ($urandom_range(0, 24) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            enable    = ($urandom_range(0, 9) != 0);
            ready     = ($urandom_range(0, 1) != 0);
            sel       = 8'($urandom);
            periodic  = ($urandom_range(0, 1) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
